envelope_generator: RTL and testbench

ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

---
 rtl/envelope_pkg.sv | 16 +
 rtl/env_scaler.sv | 20 ++
 rtl/envelope_generator.sv | 89 ++++++++
 tb/tb_envelope_generator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/envelope_pkg.sv
// envelope_pkg: shared state encoding and envelope ceiling helper for the envelope generator.
package envelope_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    function automatic logic [63:0] env_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/env_scaler.sv
// env_scaler: registered sample * level product, keeping the top SAMPLE_WIDTH bits.
module env_scaler #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int ENV_WIDTH    = 16
) (
    input  logic                    sample_clock,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic [ENV_WIDTH-1:0]    level,
    output logic [SAMPLE_WIDTH-1:0] out_sample
);

    logic [SAMPLE_WIDTH+ENV_WIDTH-1:0] product;

    assign product = {{ENV_WIDTH{1'b0}}, sample_in} * {{SAMPLE_WIDTH{1'b0}}, level};

    always_ff @(posedge sample_clock)
        out_sample <= rst ? '0 : product[SAMPLE_WIDTH+ENV_WIDTH-1:ENV_WIDTH];

endmodule

// File: rtl/envelope_generator.sv
// envelope_generator: ADSR envelope FSM with level arithmetic, shaping an unsigned sample stream.
module envelope_generator
    import envelope_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 24,
    parameter int ENV_WIDTH    = 16
) (
    input  logic                    sample_clock,
    input  logic                    rst,
    input  logic                    gate,
    input  logic [ENV_WIDTH-1:0]    attack_step,
    input  logic [ENV_WIDTH-1:0]    decay_step,
    input  logic [ENV_WIDTH-1:0]    sustain_level,
    input  logic [ENV_WIDTH-1:0]    release_step,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    output logic [SAMPLE_WIDTH-1:0] out_sample,
    output logic [ENV_WIDTH-1:0]    env_level,
    output env_state_t              env_state,
    output logic                    busy
);

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = ENV_WIDTH'(env_max(ENV_WIDTH));

    env_state_t           next_state;
    logic [ENV_WIDTH-1:0] next_level;
    logic [ENV_WIDTH:0]   sum;

    assign busy = env_state != IDLE;

    // Gate edges change state only; the level carries over so retriggers start from where they are.
    always_comb begin
        next_state = env_state;
        next_level = env_level;
        sum = {1'b0, env_level} + {1'b0, attack_step};
        case (env_state)
            IDLE: begin
                if (gate) next_state = ATTACK;
                else next_level = '0;
            end
            ATTACK: begin
                if (!gate) next_state = RELEASE;
                else if (sum >= {1'b0, ENV_MAX}) begin
                    next_level = ENV_MAX;
                    next_state = DECAY;
                end else next_level = sum[ENV_WIDTH-1:0];
            end
            DECAY: begin
                if (!gate) next_state = RELEASE;
                else if (env_level <= sustain_level || env_level - sustain_level <= decay_step) begin
                    next_level = sustain_level;
                    next_state = SUSTAIN;
                end else next_level = env_level - decay_step;
            end
            SUSTAIN: begin
                if (!gate) next_state = RELEASE;
                else next_level = sustain_level;
            end
            RELEASE: begin
                if (gate) next_state = ATTACK;
                else if (env_level <= release_step) begin
                    next_level = '0;
                    next_state = IDLE;
                end else next_level = env_level - release_step;
            end
            default: begin
                next_state = IDLE;
                next_level = '0;
            end
        endcase
    end

    always_ff @(posedge sample_clock)
        if (rst) begin
            env_state <= IDLE;
            env_level <= '0;
        end else begin
            env_state <= next_state;
            env_level <= next_level;
        end

    env_scaler #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ENV_WIDTH(ENV_WIDTH)) u_scaler (
        .sample_clock(sample_clock),
        .rst(rst),
        .sample_in(sample_in),
        .level(env_level),
        .out_sample(out_sample)
    );

endmodule

// File: tb/tb_envelope_generator.sv
// tb_envelope_generator: directed ADSR scenarios plus randomized traffic against an arithmetic reference model.
module tb_envelope_generator;
    import envelope_pkg::*;

    logic        sample_clock = 1'b0;
    logic        rst = 1'b1;
    logic        gate = 1'b0;
    logic [15:0] attack_step = '0, decay_step = '0, sustain_level = '0, release_step = '0;
    logic [23:0] sample_in = '0;
    logic [23:0] out_sample;
    logic [15:0] env_level;
    env_state_t  env_state;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int  m_st = 0;
    int  m_lv = 0;
    longint m_out = 0;
    bit  m_valid = 0;

    always #5 sample_clock = ~sample_clock;

    envelope_generator dut (
        .sample_clock(sample_clock),
        .rst(rst),
        .gate(gate),
        .attack_step(attack_step),
        .decay_step(decay_step),
        .sustain_level(sustain_level),
        .release_step(release_step),
        .sample_in(sample_in),
        .out_sample(out_sample),
        .env_level(env_level),
        .env_state(env_state),
        .busy(busy)
    );

    // Reference: states 0..4 as plain integers, level arithmetic done in wide ints and clamped.
    always @(posedge sample_clock) begin
        int a, s, d, r;
        a = int'(attack_step);
        s = int'(sustain_level);
        d = int'(decay_step);
        r = int'(release_step);
        m_out = rst ? 0 : (longint'(sample_in) * longint'(m_lv)) / 65536;
        if (rst) begin
            m_st = 0;
            m_lv = 0;
            m_valid = 1;
        end else if (gate && (m_st == 0 || m_st == 4)) m_st = 1;
        else if (!gate && m_st >= 1 && m_st <= 3) m_st = 4;
        else if (m_st == 1) begin
            if (m_lv + a >= 65535) begin m_lv = 65535; m_st = 2; end
            else m_lv = m_lv + a;
        end else if (m_st == 2) begin
            if (m_lv - d <= s) begin m_lv = s; m_st = 3; end
            else m_lv = m_lv - d;
        end else if (m_st == 3) m_lv = s;
        else if (m_st == 4) begin
            if (m_lv - r <= 0) begin m_lv = 0; m_st = 0; end
            else m_lv = m_lv - r;
        end else m_lv = 0;
    end

    always @(negedge sample_clock) if (m_valid) begin
        checks += 4;
        if (int'(env_state) != m_st) begin
            errors++;
            $display("FAIL model_state t=%0t got %0d want %0d", $time, env_state, m_st);
        end
        if (int'(env_level) != m_lv) begin
            errors++;
            $display("FAIL model_level t=%0t got %h want %h", $time, env_level, m_lv);
        end
        if (longint'(out_sample) != m_out) begin
            errors++;
            $display("FAIL model_out t=%0t got %h want %h", $time, out_sample, m_out);
        end
        if (busy != (m_st != 0)) begin
            errors++;
            $display("FAIL model_busy t=%0t got %0b want %0b", $time, busy, m_st != 0);
        end
    end

    task automatic tick();
        @(posedge sample_clock);
        #1;
    endtask

    task automatic chk(input string name, input int st, input int lv);
        checks += 2;
        if (int'(env_state) != st || int'(env_level) != lv) begin
            errors++;
            $display("FAIL %s dut state/level %0d/%h want %0d/%h", name, env_state, env_level, st, lv);
        end
        if (m_st != st || m_lv != lv) begin
            errors++;
            $display("FAIL %s model state/level %0d/%h want %0d/%h", name, m_st, m_lv, st, lv);
        end
    endtask

    task automatic chk_out(input string name, input int want);
        checks++;
        if (int'(out_sample) != want) begin
            errors++;
            $display("FAIL %s out_sample %h want %h", name, out_sample, want);
        end
    endtask

    initial begin
        gate = 1'b1;
        tick();
        tick();
        chk("reset", 0, 0);
        chk_out("reset_out", 0);
        rst = 1'b0;
        attack_step = 16'h4000;
        decay_step = 16'h3000;
        sustain_level = 16'h8000;
        release_step = 16'h0800;
        tick(); chk("attack_entry", 1, 16'h0000);
        tick(); chk("attack1", 1, 16'h4000);
        tick(); chk("attack2", 1, 16'h8000);
        tick(); chk("attack3", 1, 16'hC000);
        tick(); chk("attack_top", 2, 16'hFFFF);
        tick(); chk("decay1", 2, 16'hCFFF);
        tick(); chk("decay2", 2, 16'h9FFF);
        tick(); chk("decay_sustain", 3, 16'h8000);
        sustain_level = 16'h2000;
        tick(); chk("sustain_track", 3, 16'h2000);
        gate = 1'b0;
        tick(); chk("release_entry", 4, 16'h2000);
        tick(); chk("release1", 4, 16'h1800);
        tick(); chk("release2", 4, 16'h1000);
        tick(); chk("release3", 4, 16'h0800);
        tick(); chk("release_idle", 0, 16'h0000);
        tick(); chk("idle_hold", 0, 16'h0000);
        gate = 1'b1;
        tick(); chk("retrig_entry", 1, 16'h0000);
        tick(); tick(); chk("mid_attack", 1, 16'h8000);
        gate = 1'b0;
        tick(); chk("abort_attack", 4, 16'h8000);
        tick(); chk("abort_release", 4, 16'h7800);
        gate = 1'b1;
        tick(); chk("retrig_level", 1, 16'h7800);
        decay_step = 16'h0000;
        sustain_level = 16'h8000;
        tick(); chk("retrig_attack", 1, 16'hB800);
        tick(); tick(); chk("retrig_top", 2, 16'hFFFF);
        sample_in = 24'h000001;
        tick(); chk("decay_frozen", 2, 16'hFFFF);
        chk_out("scale_tiny", 0);
        gate = 1'b0;
        release_step = 16'h7FFF;
        tick(); tick(); chk("release_half", 4, 16'h8000);
        release_step = 16'h0000;
        sample_in = 24'hFFFFFF;
        tick(); chk("release_frozen", 4, 16'h8000);
        chk_out("scale_half", 24'h7FFFFF);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) gate = ~gate;
            if ($urandom_range(0, 15) == 0) begin
                attack_step = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h3000));
                decay_step = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h3000));
                release_step = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'h3000));
            end
            if ($urandom_range(0, 20) == 0) sustain_level = 16'($urandom);
            sample_in = 24'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
